// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for counter_ctrl: controller state encoding, counter
// idle/count encodings and the latched result record.
package counter_ctrl_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Encoding of the external counter's cnt_state output
   localparam logic CNT_ST_IDLE  = 1'b0;
   localparam logic CNT_ST_COUNT = 1'b1;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic             timeout;
   } result_t;

   // Fewer than two flops cannot both synchronize and produce an edge strobe
   function automatic int sync_depth(input int n);
      return (n < 2) ? 2 : n;
   endfunction

endpackage

// File: rtl/counter_ctrl_sig_sync.sv
// Multi-flop synchronizer for the asynchronous measured signal, with
// single-cycle rise/fall strobes taken from the last two stages.
module counter_ctrl_sig_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic sig_in,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], sig_in};
   end

   // sync_q[STAGES-1] is the older of the two sampled values
   assign rise = sync_q[STAGES-2] & ~sync_q[STAGES-1];
   assign fall = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/counter_ctrl.sv
// Pulse-width measurement controller driving an external start/stop counter.
// Optional timeout logic is built only when COUNTER_CTRL_TIMEOUT_EN is defined.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit CONTINUOUS  = 1'b0
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             arm,
   input  logic             abort,
   input  logic             sig_in,
   input  logic [CNT_W-1:0] timeout_cycles,
   output logic             cnt_start,
   output logic             cnt_stop,
   input  logic             cnt_state,
   input  logic [CNT_W-1:0] cnt_count,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_count,
   output logic             res_timeout
);

   localparam int STAGES = sync_depth(SYNC_STAGES);

   state_t  state_q, state_nxt;
   logic    tmo_flag_q, tmo_flag_nxt;
   logic    latch;
   logic    rise, fall;
   logic    tmo_hit;
   result_t res_q;

   counter_ctrl_sig_sync #(.STAGES(STAGES)) u_sig_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .sig_in (sig_in),
      .rise   (rise),
      .fall   (fall)
   );

`ifdef COUNTER_CTRL_TIMEOUT_EN
   assign tmo_hit = (cnt_count >= timeout_cycles);
`else
   logic timeout_unused;
   assign timeout_unused = |timeout_cycles;
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      state_nxt    = state_q;
      tmo_flag_nxt = tmo_flag_q;
      cnt_start    = 1'b0;
      cnt_stop     = 1'b0;
      latch        = 1'b0;
      if (abort) begin
         state_nxt = ST_IDLE;
         cnt_stop  = (state_q == ST_RUN);
      end else begin
         case (state_q)
            ST_IDLE: if (arm) state_nxt = ST_ARMED;
            ST_ARMED: begin
               if (rise) begin
                  cnt_start = 1'b1;
                  state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               // A real falling edge takes priority over a coincident timeout
               if (fall) begin
                  cnt_stop     = 1'b1;
                  tmo_flag_nxt = 1'b0;
                  state_nxt    = ST_DRAIN;
               end else if (tmo_hit) begin
                  cnt_stop     = 1'b1;
                  tmo_flag_nxt = 1'b1;
                  state_nxt    = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (cnt_state == CNT_ST_IDLE) begin
                  latch     = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               if (res_ready) state_nxt = CONTINUOUS ? ST_ARMED : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tmo_flag_q <= 1'b0;
         res_q      <= '0;
         res_valid  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         tmo_flag_q <= tmo_flag_nxt;
         if (latch) begin
            res_q.count   <= cnt_count;
            res_q.timeout <= tmo_flag_q;
         end
         // res_count survives an abort; only the valid flag is dropped
         if (abort)                                res_valid <= 1'b0;
         else if (latch)                           res_valid <= 1'b1;
         else if (state_q == ST_DONE && res_ready) res_valid <= 1'b0;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign res_count   = res_q.count;
   assign res_timeout = res_q.timeout;

endmodule
